v4_pulse_gen: RTL
=================

Name: v4_pulse_gen

Overview:
Synthetic detector-pulse source that produces ADC-format samples for the v4 shaping filter.
- On each accepted trigger it emits a linear rise followed by an exponential decay tail on top of a fixed baseline.
- It is the sample producer at the other end of the filter's input interface. It replaces the real ADC in bench and self-test configurations.
- Pile-up and dropped-trigger behaviour are deterministic, so filter outputs can be checked against a known model.

Parameters:
- SIZE_ADC_DATA, 12: output sample width, identical to the filter input width.
- BASELINE, 100: output level when idle. Must be less than 2^SIZE_ADC_DATA.
- RISE_SHIFT, 2: rise lasts 2^RISE_SHIFT cycles.
- DECAY_SHIFT, 4: per-cycle decay is acc - (acc >> DECAY_SHIFT).
- FRAC_BITS, 8: fractional bits in the internal accumulator. Must satisfy FRAC_BITS >= RISE_SHIFT and FRAC_BITS >= DECAY_SHIFT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  trigger acceptance enable.
- trig  in  1  pulse request, sampled each rising edge.
- amp  in  SIZE_ADC_DATA  pulse amplitude in ADC codes, latched when a trigger is accepted.
- adc_data  out  SIZE_ADC_DATA  generated sample, registered.
- busy  out  1  high whenever the state is not IDLE.
- pulse_start  out  1  one-cycle strobe on the edge a trigger is accepted.
- sat  out  1  high in any cycle where adc_data was clipped to the maximum code.
- drop_cnt  out  8  count of triggers dropped during RISE; saturates at 255.
- pile_cnt  out  8  count of triggers accepted during DECAY; saturates at 255.

Behaviour:
- Accumulator
  - acc is unsigned, SIZE_ADC_DATA+FRAC_BITS+2 bits wide. It never wraps.
  - When acc + step would exceed the all-ones value, acc is clamped to all-ones.
  - step = (amp << FRAC_BITS) >> RISE_SHIFT, computed at acceptance and held until the next acceptance. The shift is exact, so a full rise adds exactly amp << FRAC_BITS.
- Output
  - adc_data is a register loaded on the same edge as acc, from acc's new value: min(BASELINE + (acc >> FRAC_BITS), 2^SIZE_ADC_DATA - 1).
  - sat is registered alongside adc_data and is high only in cycles where that clip was applied.
- Reset (asynchronous, any time including mid-pulse)
  - state=IDLE, acc=0, step=0, rise counter=0.
  - adc_data=BASELINE, busy=0, pulse_start=0, sat=0, drop_cnt=0, pile_cnt=0.
  - Normal operation resumes from the first clock edge after reset deasserts.
- IDLE
  - acc held at 0; adc_data=BASELINE.
  - On trig&&enable: latch amp, compute step, clear the rise counter, go to RISE, pulse_start=1 for one cycle. acc is unchanged on this edge.
- RISE
  - Each edge: acc += step, counter++.
  - On the edge where the counter reaches 2^RISE_SHIFT, go to DECAY.
  - If trig&&enable is seen in RISE, the trigger is dropped and drop_cnt increments by 1, saturating at 255.
- DECAY
  - Each edge: acc <= acc - (acc >> DECAY_SHIFT).
  - If the new acc >> FRAC_BITS == 0: go to IDLE and force acc=0.
  - If trig&&enable is seen in DECAY (pile-up): this edge does not decay. Latch the new amp and step, clear the counter, go to RISE with acc retained, pulse_start=1, and pile_cnt increments, saturating at 255.
  - The new rise stacks on the residual level, with clamping as above.
- enable low
  - Triggers are ignored and not counted.
  - A pulse already in progress completes normally.
- Timing
  - With trig accepted on edge E0, the rise samples appear after E1 through E(2^RISE_SHIFT).
  - The peak, BASELINE+amp unless clipped, appears after E(2^RISE_SHIFT).
  - Decay begins on the following edge.

Test Plan:
1. Reset check: assert reset for 3 cycles with trig=1 -> adc_data=100, busy=0, both counters 0. Deassert reset mid-cycle; the first edge after deassertion may already accept trig.
2. Single pulse, amp=400, enable=1, one-cycle trig -> pulse_start one cycle, busy=1.
   - adc_data after E1 to E4 = 200, 300, 400, 500.
   - Decay samples then = 475, 451, and so on.
   - Eventually adc_data=100 and busy=0.
3. Saturation, amp=4095 -> adc_data clips at 4095 with sat=1 in the clipped cycles. sat returns to 0 once BASELINE plus the decayed level drops below 4095.
4. Dropped trigger: trig during cycle 2 of RISE -> drop_cnt=1, pulse_start not reasserted, waveform identical to case 2.
5. Pile-up, amp=400: second trig, amp=200, on the first DECAY edge -> no decay on that edge. adc_data rises from 500 by 50 per edge, peaking at 700. pile_cnt=1.
6. Reset mid-DECAY: assert reset asynchronously -> adc_data=100 and busy=0 immediately, without waiting for a clock. After release with enable=0 and trig pulses, the output stays at 100 and the counters stay at 0.

Source files
------------

// File: rtl/v4_pulse_gen.sv
// Synthetic detector-pulse source for the v4 shaping filter.
// Linear rise, exponential decay tail, deterministic pile-up and drop.
module v4_pulse_gen #(
  parameter int SIZE_ADC_DATA = 12,
  parameter int BASELINE      = 100,
  parameter int RISE_SHIFT    = 2,
  parameter int DECAY_SHIFT   = 4,
  parameter int FRAC_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     trig,
  input  logic [SIZE_ADC_DATA-1:0] amp,
  output logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic                     busy,
  output logic                     pulse_start,
  output logic                     sat,
  output logic [7:0]               drop_cnt,
  output logic [7:0]               pile_cnt
);

  localparam int W    = SIZE_ADC_DATA;
  localparam int ACCW = W + FRAC_BITS + 2;
  localparam int CW   = RISE_SHIFT + 1;
  localparam logic [CW-1:0] RISE_LEN = CW'(2**RISE_SHIFT);
  localparam logic [W+2:0]  MAXC     = (W+3)'((2**W) - 1);
  localparam logic [W+2:0]  BASE     = (W+3)'(BASELINE);

  typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

  state_t state, state_n;

  logic [ACCW-1:0] acc, acc_n, step, step_n;
  logic [ACCW-1:0] step_new, acc_add, acc_dec;
  logic [ACCW:0]   add_w;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [7:0]      drop_n, pile_n;
  logic            ps_n, fire, dec_zero;
  logic [W+2:0]    lvl;
  logic            clip;
  logic [W-1:0]    adc_n;

  assign fire     = trig & enable;
  assign step_new = ACCW'(amp) << (FRAC_BITS - RISE_SHIFT);
  assign add_w    = {1'b0, acc} + {1'b0, step};
  assign acc_add  = add_w[ACCW] ? '1 : add_w[ACCW-1:0];
  assign acc_dec  = acc - (acc >> DECAY_SHIFT);
  assign dec_zero = (acc_dec[ACCW-1:FRAC_BITS] == '0);
  assign cnt_inc  = cnt + 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (fire) state_n = RISE;
      RISE:    if (cnt_inc == RISE_LEN) state_n = DECAY;
      DECAY: begin
        if (fire)          state_n = RISE;
        else if (dec_zero) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    acc_n  = acc;
    step_n = step;
    cnt_n  = cnt;
    ps_n   = 1'b0;
    drop_n = drop_cnt;
    pile_n = pile_cnt;
    unique case (state)
      IDLE: begin
        acc_n = '0;
        if (fire) begin
          step_n = step_new;
          cnt_n  = '0;
          ps_n   = 1'b1;
        end
      end
      RISE: begin
        acc_n = acc_add;
        cnt_n = cnt_inc;
        if (fire && drop_cnt != 8'hff) drop_n = drop_cnt + 8'd1;
      end
      DECAY: begin
        // a pile-up skips this edge's decay and restacks on the residual
        if (fire) begin
          step_n = step_new;
          cnt_n  = '0;
          ps_n   = 1'b1;
          if (pile_cnt != 8'hff) pile_n = pile_cnt + 8'd1;
        end else begin
          acc_n = dec_zero ? '0 : acc_dec;
        end
      end
      default: acc_n = '0;
    endcase
  end

  assign lvl   = BASE + {1'b0, acc_n[ACCW-1:FRAC_BITS]};
  assign clip  = (lvl > MAXC);
  assign adc_n = clip ? '1 : lvl[W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      step        <= '0;
      cnt         <= '0;
      adc_data    <= W'(BASELINE);
      sat         <= 1'b0;
      pulse_start <= 1'b0;
      drop_cnt    <= 8'd0;
      pile_cnt    <= 8'd0;
    end else begin
      acc         <= acc_n;
      step        <= step_n;
      cnt         <= cnt_n;
      adc_data    <= adc_n;
      sat         <= clip;
      pulse_start <= ps_n;
      drop_cnt    <= drop_n;
      pile_cnt    <= pile_n;
    end
  end

endmodule
